visor_resultado: RTL and testbench

//  Output-side counterpart of the operand loader. Shows the ALU operands (A, B),
//  the opcode and the ALU result on the board LEDs, one value at a time.
//  The operator steps through the values with one push-button. The block is

---
 rtl/visor_resultado_if.sv | 25 ++
 rtl/visor_resultado.sv | 140 ++++++++++++++
 tb/tb_visor_resultado.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/visor_resultado_if.sv
// Bundle between the ALU/loader side and the LED display block.
// master drives operands and the button; slave drives the LED outputs.
interface visor_resultado_if #(
    parameter int BUS = 8,
    parameter int OP  = 6
);
    logic [BUS-1:0] a;
    logic [BUS-1:0] b;
    logic [OP-1:0]  op;
    logic [BUS-1:0] resultado;
    logic           boton_sig;
    logic [BUS-1:0] salida;
    logic [1:0]     pagina;
    logic           cambio;

    modport master (
        output a, b, op, resultado, boton_sig,
        input  salida, pagina, cambio
    );

    modport slave (
        input  a, b, op, resultado, boton_sig,
        output salida, pagina, cambio
    );
endinterface

// File: rtl/visor_resultado.sv
// Paged LED viewer for A, B, opcode and ALU result, stepped by one button.
// Optional macro AUTO_SCROLL_EN adds a timed automatic page advance.
module visor_resultado #(
    parameter int BUS        = 8,
    parameter int OP         = 6,
    parameter int DEB_CYCLES = 16
`ifdef AUTO_SCROLL_EN
    ,
    parameter int SCROLL_DIV = 50000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    visor_resultado_if.slave vis
);

    typedef enum logic [1:0] {
        PAG_A   = 2'd0,
        PAG_B   = 2'd1,
        PAG_OP  = 2'd2,
        PAG_RES = 2'd3
    } pag_t;

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_estable;
    logic          r_estable_q;
    logic [CW-1:0] r_cnt;
    pag_t          r_pag;
    logic          r_cambio;
    logic [BUS-1:0] r_salida;

    logic           w_sube;
    logic           w_tick;
    logic           w_avanza;
    logic [BUS-1:0] w_op_ext;

    assign w_sube   = r_estable & ~r_estable_q;
    assign w_avanza = w_sube | w_tick;
    assign w_op_ext = BUS'(vis.op);

    // Two-flop synchroniser for the raw button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= vis.boton_sig;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estable <= 1'b0;
            r_cnt     <= '0;
        end else if (r_s2 == r_estable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_estable <= ~r_estable;
            r_cnt     <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed debounced level for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estable_q <= 1'b0;
        end else begin
            r_estable_q <= r_estable;
        end
    end

`ifdef AUTO_SCROLL_EN
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCROLL_DIV - 1);

    logic [DW-1:0] r_div;

    assign w_tick = (r_div == DIV_MAX);

    // Scroll divider; a manual press restarts the interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_sube || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end
`else
    assign w_tick = 1'b0;
`endif

    // Page FSM; press and tick together still advance only one page
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pag    <= PAG_A;
            r_cambio <= 1'b0;
        end else begin
            r_cambio <= w_avanza;
            if (w_avanza) begin
                unique case (r_pag)
                    PAG_A:   r_pag <= PAG_B;
                    PAG_B:   r_pag <= PAG_OP;
                    PAG_OP:  r_pag <= PAG_RES;
                    PAG_RES: r_pag <= PAG_A;
                    default: r_pag <= PAG_A;
                endcase
            end
        end
    end

    // LED value follows the live source of the registered page
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_salida <= '0;
        end else begin
            unique case (r_pag)
                PAG_A:   r_salida <= vis.a;
                PAG_B:   r_salida <= vis.b;
                PAG_OP:  r_salida <= w_op_ext;
                PAG_RES: r_salida <= vis.resultado;
                default: r_salida <= '0;
            endcase
        end
    end

    assign vis.salida = r_salida;
    assign vis.pagina = r_pag;
    assign vis.cambio = r_cambio;

endmodule

// File: tb/tb_visor_resultado.sv
// Directed bench for visor_resultado with DEB_CYCLES=4.
// With AUTO_SCROLL_EN defined it runs the auto-scroll scenario instead.
module tb_visor_resultado;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    visor_resultado_if #(.BUS(8), .OP(6)) vif ();

    visor_resultado #(
        .BUS        (8),
        .OP         (6),
        .DEB_CYCLES (4)
`ifdef AUTO_SCROLL_EN
        ,
        .SCROLL_DIV (8)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vis   (vif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] exp_pag, input logic [7:0] exp_sal);
        logic seen;
        seen = 1'b0;
        vif.boton_sig = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vif.cambio) begin
                seen = 1'b1;
                break;
            end
        end
        chk("press_seen", {31'd0, seen}, 32'd1);
        chk("press_pag", {30'd0, vif.pagina}, {30'd0, exp_pag});
        step();
        chk("press_cambio_off", {31'd0, vif.cambio}, 32'd0);
        chk("press_sal", {24'd0, vif.salida}, {24'd0, exp_sal});
        vif.boton_sig = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        vif.a         = 8'hA5;
        vif.b         = 8'h5A;
        vif.op        = 6'h00;
        vif.resultado = 8'h00;
        vif.boton_sig = 1'b0;

`ifdef AUTO_SCROLL_EN
        repeat (2) step();
        reset = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            step();
            if (e == 17) vif.boton_sig = 1'b1;
            if (e == 25) vif.boton_sig = 1'b0;
            if (e == 7)  chk("auto_e7", {30'd0, vif.pagina}, 32'd0);
            if (e == 8)  chk("auto_e8", {30'd0, vif.pagina}, 32'd1);
            if (e == 8)  chk("auto_cam8", {31'd0, vif.cambio}, 32'd1);
            if (e == 16) chk("auto_e16", {30'd0, vif.pagina}, 32'd2);
            if (e == 23) chk("auto_e23", {30'd0, vif.pagina}, 32'd2);
            if (e == 24) chk("coinc_e24", {30'd0, vif.pagina}, 32'd3);
            if (e == 24) chk("coinc_cam", {31'd0, vif.cambio}, 32'd1);
            if (e == 25) chk("coinc_e25", {30'd0, vif.pagina}, 32'd3);
            if (e == 31) chk("restart_e31", {30'd0, vif.pagina}, 32'd3);
            if (e == 32) chk("restart_e32", {30'd0, vif.pagina}, 32'd0);
        end
`else
        // 1: reset in the middle of a debounce
        repeat (2) step();
        reset = 1'b0;
        vif.boton_sig = 1'b1;
        repeat (3) step();
        chk("pre_rst_sal", {24'd0, vif.salida}, 32'hA5);
        reset = 1'b1;
        #1;
        chk("rst_pag", {30'd0, vif.pagina}, 32'd0);
        chk("rst_sal", {24'd0, vif.salida}, 32'd0);
        chk("rst_cam", {31'd0, vif.cambio}, 32'd0);
        vif.boton_sig = 1'b0;
        step();
        reset = 1'b0;
        chk("rel_sal0", {24'd0, vif.salida}, 32'd0);
        step();
        chk("rel_sal", {24'd0, vif.salida}, 32'hA5);
        chk("rel_pag", {30'd0, vif.pagina}, 32'd0);

        // 2: latency of a clean press
        vif.boton_sig = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            step();
            chk($sformatf("lat_pag%0d", n), {30'd0, vif.pagina},
                (n >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("lat_cam%0d", n), {31'd0, vif.cambio},
                (n == 6) ? 32'd1 : 32'd0);
        end
        chk("lat_sal_b", {24'd0, vif.salida}, 32'h5A);
        vif.boton_sig = 1'b0;
        repeat (10) step();
        chk("release_pag", {30'd0, vif.pagina}, 32'd1);

        // 3: short bounces never get through
        reset = 1'b1;
        step();
        reset = 1'b0;
        begin
            logic seen_cam;
            seen_cam = 1'b0;
            vif.boton_sig = 1'b1;
            step();
            seen_cam |= vif.cambio;
            vif.boton_sig = 1'b0;
            step();
            seen_cam |= vif.cambio;
            vif.boton_sig = 1'b1;
            step();
            seen_cam |= vif.cambio;
            vif.boton_sig = 1'b0;
            for (int i = 0; i < 15; i++) begin
                step();
                seen_cam |= vif.cambio;
            end
            chk("bounce_cam", {31'd0, seen_cam}, 32'd0);
            chk("bounce_pag", {30'd0, vif.pagina}, 32'd0);
        end

        // 4: full cycle through the pages with wrap
        vif.a         = 8'h01;
        vif.b         = 8'h02;
        vif.op        = 6'h3F;
        vif.resultado = 8'h80;
        press(2'd1, 8'h02);
        press(2'd2, 8'h3F);
        press(2'd3, 8'h80);
        press(2'd0, 8'h01);

        // 5: result page tracks a live input change
        press(2'd1, 8'h02);
        press(2'd2, 8'h3F);
        press(2'd3, 8'h80);
        vif.resultado = 8'h10;
        step();
        chk("res_10", {24'd0, vif.salida}, 32'h10);
        vif.resultado = 8'h20;
        step();
        chk("res_20", {24'd0, vif.salida}, 32'h20);
        chk("res_pag", {30'd0, vif.pagina}, 32'd3);
        chk("res_cam", {31'd0, vif.cambio}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
